// File: rtl/rand_delay_ctrl.sv
// rand_delay_ctrl
//   Sequencer for the shared 12-bit LFSR in the reaction-timer game. On start
//   it requests one LFSR step, waits for the LFSR to report ready (with a
//   timeout fallback), turns the captured value into a bounded delay in
//   milliseconds, counts that delay down and then raises go until the player
//   presses. A press during the countdown is reported as a false start.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start        1-cycle pulse, begin a round (only honoured in IDLE)
//   press        1-cycle pulse, debounced player key
//   abort        1-cycle pulse, cancel the current round
//   lfsr_val     current LFSR output
//   lfsr_ready   LFSR output valid after a step
//   lfsr_step    1-cycle request to advance the LFSR
//   go           level, high from delay expiry until press/abort
//   false_start  1-cycle pulse, press during the countdown
//   done         1-cycle pulse, valid press while go is high
//   fetch_fault  sticky, last fetch timed out; cleared by the next start
//   busy         high in every state except IDLE
//   delay_ms     delay chosen for the current/last round
//   state_dbg    encoded state for LEDs (IDLE=0 FETCH=1 WAIT=2 GO=3)

module rand_delay_ctrl #(
    parameter int CLK_PER_MS = 50000,
    parameter int MIN_MS     = 1000,
    parameter int RAND_BITS  = 11,
    parameter int FETCH_TO   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        press,
    input  logic        abort,
    input  logic [11:0] lfsr_val,
    input  logic        lfsr_ready,
    output logic        lfsr_step,
    output logic        go,
    output logic        false_start,
    output logic        done,
    output logic        fetch_fault,
    output logic        busy,
    output logic [15:0] delay_ms,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GO    = 2'd3;

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int FW = (FETCH_TO > 1) ? $clog2(FETCH_TO) : 1;

    localparam logic [PW-1:0] PRESC_RELOAD = PW'(CLK_PER_MS - 1);
    localparam logic [FW-1:0] FETCH_LAST   = FW'(FETCH_TO - 1);
    localparam logic [15:0]   MIN_DELAY    = 16'(MIN_MS);
    localparam logic [11:0]   RAND_MASK    = 12'((1 << RAND_BITS) - 1);

    logic [1:0]    state, state_n;
    logic [FW-1:0] fetch_cnt, fetch_cnt_n;
    logic [PW-1:0] presc, presc_n;
    logic [15:0]   ms_left, ms_left_n;
    logic [15:0]   delay_n;
    logic [15:0]   captured;
    logic          step_n, go_n, fs_n, done_n, fault_n, busy_n;

    // Bounded random delay: only the low RAND_BITS of the LFSR contribute.
    assign captured  = MIN_DELAY + {4'b0000, lfsr_val & RAND_MASK};
    assign state_dbg = state;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_n     = state;
        fetch_cnt_n = fetch_cnt;
        presc_n     = presc;
        ms_left_n   = ms_left;
        delay_n     = delay_ms;
        fault_n     = fetch_fault;
        go_n        = go;
        step_n      = 1'b0;
        fs_n        = 1'b0;
        done_n      = 1'b0;

        case (state)
            S_IDLE: begin
                go_n = 1'b0;
                if (start) begin
                    state_n     = S_FETCH;
                    step_n      = 1'b1;
                    fault_n     = 1'b0;
                    fetch_cnt_n = '0;
                end
            end

            S_FETCH: begin
                if (abort || press) begin
                    state_n = S_IDLE;
                end else if (lfsr_ready) begin
                    delay_n   = captured;
                    ms_left_n = captured;
                    presc_n   = PRESC_RELOAD;
                    state_n   = S_WAIT;
                end else if (fetch_cnt == FETCH_LAST) begin
                    // LFSR never answered: fall back to the minimum delay.
                    delay_n   = MIN_DELAY;
                    ms_left_n = MIN_DELAY;
                    presc_n   = PRESC_RELOAD;
                    fault_n   = 1'b1;
                    state_n   = S_WAIT;
                end else begin
                    fetch_cnt_n = fetch_cnt + 1'b1;
                end
            end

            S_WAIT: begin
                // abort beats press, press beats expiry in the same cycle.
                if (abort) begin
                    state_n = S_IDLE;
                end else if (press) begin
                    fs_n    = 1'b1;
                    state_n = S_IDLE;
                end else if (presc == '0) begin
                    presc_n = PRESC_RELOAD;
                    if (ms_left <= 16'd1) begin
                        ms_left_n = '0;
                        go_n      = 1'b1;
                        state_n   = S_GO;
                    end else begin
                        ms_left_n = ms_left - 16'd1;
                    end
                end else begin
                    presc_n = presc - 1'b1;
                end
            end

            default: begin  // S_GO
                if (abort) begin
                    go_n    = 1'b0;
                    state_n = S_IDLE;
                end else if (press) begin
                    done_n  = 1'b1;
                    go_n    = 1'b0;
                    state_n = S_IDLE;
                end
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            fetch_cnt   <= '0;
            presc       <= '0;
            ms_left     <= '0;
            delay_ms    <= '0;
            fetch_fault <= 1'b0;
            go          <= 1'b0;
            lfsr_step   <= 1'b0;
            false_start <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            fetch_cnt   <= fetch_cnt_n;
            presc       <= presc_n;
            ms_left     <= ms_left_n;
            delay_ms    <= delay_n;
            fetch_fault <= fault_n;
            go          <= go_n;
            lfsr_step   <= step_n;
            false_start <= fs_n;
            done        <= done_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_rand_delay_ctrl.sv
// Self-checking bench for rand_delay_ctrl with small parameters.
// A round is described by a scenario (LFSR value, ready edge, press edge
// relative to the capture edge, abort/start-spam options); the expected
// outcome comes either from a hand-written table or from a behavioural
// model that works purely from delay arithmetic.

module tb_rand_delay_ctrl;

    localparam int CPM  = 4;
    localparam int MINM = 2;
    localparam int RB   = 3;
    localparam int FTO  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        press = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] lfsr_val = '0;
    logic        lfsr_ready = 1'b0;
    logic        lfsr_step, go, false_start, done, fetch_fault, busy;
    logic [15:0] delay_ms;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int last_delay = 0;

    rand_delay_ctrl #(
        .CLK_PER_MS(CPM), .MIN_MS(MINM), .RAND_BITS(RB), .FETCH_TO(FTO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .press(press), .abort(abort),
        .lfsr_val(lfsr_val), .lfsr_ready(lfsr_ready), .lfsr_step(lfsr_step),
        .go(go), .false_start(false_start), .done(done),
        .fetch_fault(fetch_fault), .busy(busy), .delay_ms(delay_ms),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] val;
        int          rdy;    // edge after start with lfsr_ready=1 (0 = never)
        int          p;      // press edge, counted from the capture edge
        bit          ab;     // abort together with the press
        bit          spam;   // start on every WAIT/GO edge before the press
        bit          pws;    // press together with the start pulse
    } scen_t;

    typedef struct {
        int delay;
        int fault;
        int rise;            // go rise, edges after capture (-1 = never)
        int done;
        int fs;
    } exp_t;

    typedef struct {
        scen_t sc;
        exp_t  ex;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int all_outputs();
        return int'({go, busy, lfsr_step, false_start, done, fetch_fault,
                     state_dbg, delay_ms});
    endfunction

    // Capture happens at the ready edge if it falls inside the fetch window,
    // otherwise at the timeout edge.
    function automatic int cap_edge(input int rdy);
        return (rdy >= 1 && rdy <= FTO) ? rdy : FTO;
    endfunction

    // Behavioural model: delay from the LFSR value, go after delay*CPM
    // cycles, press before/at expiry is a false start, abort cancels.
    function automatic exp_t predict(input scen_t sc);
        exp_t e;
        bit   ok;
        int   t;
        ok      = (sc.rdy >= 1 && sc.rdy <= FTO);
        e.delay = ok ? MINM + (int'(sc.val) % (1 << RB)) : MINM;
        e.fault = ok ? 0 : 1;
        t       = e.delay * CPM;
        if (sc.p <= t) begin
            e.rise = -1;
            e.done = 0;
            e.fs   = sc.ab ? 0 : 1;
        end else begin
            e.rise = t;
            e.done = sc.ab ? 0 : 1;
            e.fs   = 0;
        end
        return e;
    endfunction

    task automatic run_round(input scen_t sc, input exp_t ex, input string tag);
        int c, step_late, go_first, go_cnt, done_cnt, done_at, fs_cnt, fs_at;
        int d_obs, f_obs, st_cap, st_rise, go_len;
        c = cap_edge(sc.rdy);
        step_late = 0; go_first = -1; go_cnt = 0;
        done_cnt = 0; done_at = -1; fs_cnt = 0; fs_at = -1;
        d_obs = -1; f_obs = -1; st_cap = -1; st_rise = -1;
        go_len = (ex.rise >= 0) ? sc.p - ex.rise : 0;

        lfsr_val = sc.val;
        start = 1'b1;
        press = sc.pws;
        step();
        start = 1'b0;
        press = 1'b0;
        check({tag, " step_first"}, int'(lfsr_step), 1);
        check({tag, " fault_cleared"}, int'(fetch_fault), 0);
        check({tag, " st_fetch"}, int'(state_dbg), 1);
        check({tag, " busy"}, int'(busy), 1);

        for (int j = 1; j <= c + sc.p; j++) begin
            lfsr_ready = (j == sc.rdy);
            press      = (j == c + sc.p);
            abort      = sc.ab && (j == c + sc.p);
            start      = sc.spam && (j > c) && (j < c + sc.p);
            step();
            lfsr_ready = 1'b0;
            press      = 1'b0;
            abort      = 1'b0;
            start      = 1'b0;
            if (lfsr_step) step_late++;
            if (j == c) begin
                d_obs  = int'(delay_ms);
                f_obs  = int'(fetch_fault);
                st_cap = int'(state_dbg);
            end
            if (go) begin
                go_cnt++;
                if (go_first < 0) begin
                    go_first = j - c;
                    st_rise  = int'(state_dbg);
                end
            end
            if (done) begin done_cnt++; done_at = j - c; end
            if (false_start) begin fs_cnt++; fs_at = j - c; end
        end

        check({tag, " step_extra"}, step_late, 0);
        check({tag, " delay_ms"}, d_obs, ex.delay);
        check({tag, " fetch_fault"}, f_obs, ex.fault);
        check({tag, " st_wait"}, st_cap, 2);
        check({tag, " go_rise"}, go_first, ex.rise);
        check({tag, " go_len"}, go_cnt, go_len);
        if (ex.rise >= 0) check({tag, " st_go"}, st_rise, 3);
        check({tag, " done_cnt"}, done_cnt, ex.done);
        check({tag, " done_at"}, done_at, ex.done ? sc.p : -1);
        check({tag, " fs_cnt"}, fs_cnt, ex.fs);
        check({tag, " fs_at"}, fs_at, ex.fs ? sc.p : -1);
        check({tag, " end_busy"}, int'(busy), 0);
        check({tag, " end_state"}, int'(state_dbg), 0);
        check({tag, " delay_hold"}, int'(delay_ms), ex.delay);

        // A stray press in IDLE must produce nothing.
        press = 1'b1;
        step();
        press = 1'b0;
        step();
        check({tag, " idle_press"}, int'({done, false_start, go, busy}), 0);
        last_delay = ex.delay;
    endtask

    // start, then press or abort during FETCH: silent return to IDLE.
    task automatic fetch_cancel(input bit use_abort, input string tag);
        lfsr_val = 12'h3C1;
        start = 1'b1;
        step();
        start = 1'b0;
        press = !use_abort;
        abort = use_abort;
        step();
        press = 1'b0;
        abort = 1'b0;
        check({tag, " idle"}, int'({busy, state_dbg}), 0);
        check({tag, " pulses"}, int'({done, false_start, go}), 0);
        check({tag, " delay_kept"}, int'(delay_ms), last_delay);
        step();
        check({tag, " no_step"}, int'(lfsr_step), 0);
    endtask

    vec_t  vecs[11];
    scen_t rs;
    exp_t  re;

    initial begin
        vecs[0]  = '{'{12'h005, 2, 33, 1'b0, 1'b0, 1'b0}, '{7, 0, 28, 1, 0}};
        vecs[1]  = '{'{12'hFFF, 1, 38, 1'b0, 1'b0, 1'b0}, '{9, 0, 36, 1, 0}};
        vecs[2]  = '{'{12'h008, 3,  9, 1'b0, 1'b0, 1'b0}, '{2, 0,  8, 1, 0}};
        vecs[3]  = '{'{12'h003, 2, 10, 1'b0, 1'b0, 1'b0}, '{5, 0, -1, 0, 1}};
        vecs[4]  = '{'{12'h000, 0, 11, 1'b0, 1'b0, 1'b0}, '{2, 1,  8, 1, 0}};
        vecs[5]  = '{'{12'h004, 2, 24, 1'b0, 1'b0, 1'b0}, '{6, 0, -1, 0, 1}};
        vecs[6]  = '{'{12'h001, 2, 16, 1'b1, 1'b0, 1'b0}, '{3, 0, 12, 0, 0}};
        vecs[7]  = '{'{12'h002, 1, 18, 1'b0, 1'b1, 1'b0}, '{4, 0, 16, 1, 0}};
        vecs[8]  = '{'{12'h006, 2, 33, 1'b0, 1'b0, 1'b1}, '{8, 0, 32, 1, 0}};
        vecs[9]  = '{'{12'h007, 8, 37, 1'b0, 1'b0, 1'b0}, '{9, 0, 36, 1, 0}};
        vecs[10] = '{'{12'h005, 9,  5, 1'b1, 1'b0, 1'b0}, '{2, 1, -1, 0, 0}};

        // Reset state, then synchronous recovery into IDLE.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outputs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_reset_outputs", all_outputs(), 0);

        for (int i = 0; i < 11; i++)
            run_round(vecs[i].sc, vecs[i].ex, $sformatf("vec%0d", i));

        fetch_cancel(1'b0, "fetch_press");
        fetch_cancel(1'b1, "fetch_abort");

        for (int i = 0; i < 30; i++) begin
            rs.val  = 12'($urandom);
            rs.rdy  = $urandom_range(0, 10);
            rs.p    = 1;
            rs.ab   = ($urandom_range(0, 3) == 0);
            rs.spam = ($urandom_range(0, 1) == 1);
            rs.pws  = ($urandom_range(0, 3) == 0);
            re      = predict(rs);
            rs.p    = $urandom_range(1, re.delay * CPM + 6);
            re      = predict(rs);
            run_round(rs, re, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of WAIT clears without an edge.
        lfsr_val = 12'h005;
        start = 1'b1;
        step();
        start = 1'b0;
        lfsr_ready = 1'b1;
        step();
        lfsr_ready = 1'b0;
        repeat (5) step();
        check("mid_wait_busy", int'({busy, state_dbg}), 6);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outputs(), 0);
        #1 rst_n = 1'b1;
        step();
        check("async_recover_outputs", all_outputs(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
